risc_core_mc: RTL and testbench

RISC_CORE_MC -- requirements
Module: risc_core_mc

---
 rtl/risc_core_mc.sv | 250 +++++++++++++++++++++++++
 tb/tb_risc_core_mc.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_core_mc.sv
// Multi-cycle accumulator-free RISC core: fetch/execute FSM over a single
// request/acknowledge memory port, NREGS-deep register file and 5-bit status word.
module risc_core_mc #(
   parameter int WIDTH    = 32,
   parameter int ADDRSIZE = 12,
   parameter int NREGS    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDRSIZE-1:0] mem_addr,
   output logic [WIDTH-1:0]    mem_wdata,
   input  logic [WIDTH-1:0]    mem_rdata,
   input  logic                mem_ack,
   output logic [ADDRSIZE-1:0] pc,
   output logic [4:0]          psr,
   output logic                halted,
   output logic                illegal
);

   localparam int RIDX = $clog2(NREGS);

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_BRA = 4'd1;
   localparam logic [3:0] OP_LD  = 4'd2;
   localparam logic [3:0] OP_STR = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4;
   localparam logic [3:0] OP_MUL = 4'd5;
   localparam logic [3:0] OP_CMP = 4'd6;
   localparam logic [3:0] OP_SHF = 4'd7;
   localparam logic [3:0] OP_ROT = 4'd8;
   localparam logic [3:0] OP_HLT = 4'd9;

   typedef enum logic [2:0] {HALT, FETCH, EXEC, MEMRD, MEMWR, WRITE} state_t;

   state_t              state;
   logic [31:0]         ir;
   logic [WIDTH-1:0]    regs [NREGS];
   logic [WIDTH-1:0]    alu_q;

   logic [3:0]          opcode;
   logic                srctype;
   logic                dsttype;
   logic [3:0]          ccode;
   logic [RIDX-1:0]     src_idx;
   logic [RIDX-1:0]     dst_idx;
   logic [ADDRSIZE-1:0] src_addr;
   logic [ADDRSIZE-1:0] dst_addr;
   logic [WIDTH-1:0]    imm;
   logic [WIDTH-1:0]    s1;
   logic [WIDTH-1:0]    d;
   logic                ack;
   logic                taken;

   logic                c_neg;
   logic [12:0]         c_mag;
   logic [31:0]         c_mod;
   logic [31:0]         rot_r;
   logic [WIDTH-1:0]    shf;
   logic [WIDTH-1:0]    rot;
   logic [WIDTH:0]      alu_res;

   assign opcode   = ir[31:28];
   assign srctype  = ir[27];
   assign dsttype  = ir[26];
   assign ccode    = ir[27:24];
   assign src_idx  = ir[12 +: RIDX];
   assign dst_idx  = ir[0 +: RIDX];
   assign src_addr = ir[12 +: ADDRSIZE];
   assign dst_addr = ir[0 +: ADDRSIZE];
   assign imm      = {{(WIDTH-12){1'b0}}, ir[23:12]};
   assign s1       = srctype ? imm : regs[src_idx];
   assign d        = regs[dst_idx];
   // An ack with no request outstanding is noise and must not advance anything.
   assign ack      = mem_ack & mem_req;

   function automatic logic [4:0] flags(input logic [WIDTH:0] r);
      return {r[WIDTH-1], ~|r, ^r, ~r[0], r[WIDTH]};
   endfunction

   always_comb begin
      case (ccode)
         4'd0:    taken = 1'b1;
         4'd1:    taken = psr[0];
         4'd2:    taken = psr[1];
         4'd3:    taken = psr[2];
         4'd4:    taken = psr[3];
         4'd5:    taken = psr[4];
         default: taken = 1'b0;
      endcase
   end

   // Shift/rotate count is s1[11:0] read as a signed 12-bit value.
   always_comb begin
      c_neg = s1[11];
      c_mag = c_neg ? (13'h1000 - {1'b0, s1[11:0]}) : {1'b0, s1[11:0]};
      c_mod = 32'(c_mag) % 32'(WIDTH);
      rot_r = (c_neg && c_mod != 32'd0) ? (32'(WIDTH) - c_mod) : c_mod;

      if (32'(c_mag) >= 32'(WIDTH)) shf = '0;
      else if (c_neg)                shf = d << c_mag;
      else                           shf = d >> c_mag;

      // A shift by WIDTH yields zero, so rot_r == 0 leaves d intact.
      rot = (d >> rot_r) | (d << (32'(WIDTH) - rot_r));

      // NOTE: every path assigns alu_res (default arm), so no latch is inferred.
      case (opcode)
         OP_ADD:  alu_res = {1'b0, s1} + {1'b0, d};
         OP_MUL:  alu_res = {1'b0, s1} * {1'b0, d};
         OP_CMP:  alu_res = {1'b0, ~s1};
         OP_SHF:  alu_res = {1'b0, shf};
         OP_ROT:  alu_res = {1'b0, rot};
         default: alu_res = '0;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values; later assignments in a branch override the defaults.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= HALT;
         pc        <= '0;
         psr       <= '0;
         ir        <= '0;
         alu_q     <= '0;
         illegal   <= 1'b0;
         halted    <= 1'b1;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         // NOTE: the register file is flops, not RAM, so it is cleared by reset.
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         case (state)
            HALT: begin
               if (start) begin
                  state    <= FETCH;
                  halted   <= 1'b0;
                  illegal  <= 1'b0;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end
            end

            FETCH: begin
               if (ack) begin
                  ir      <= mem_rdata[31:0];
                  pc      <= pc + ADDRSIZE'(1);
                  state   <= EXEC;
                  mem_req <= 1'b0;
               end
            end

            EXEC: begin
               state    <= FETCH;
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= pc;
               case (opcode)
                  OP_NOP: ;
                  OP_BRA: begin
                     if (taken) begin
                        pc       <= dst_addr;
                        mem_addr <= dst_addr;
                     end
                  end
                  OP_LD: begin
                     if (srctype) begin
                        regs[dst_idx] <= imm;
                        psr           <= flags({1'b0, imm});
                     end else begin
                        state    <= MEMRD;
                        mem_addr <= src_addr;
                     end
                  end
                  OP_STR: begin
                     state     <= MEMWR;
                     mem_we    <= 1'b1;
                     mem_addr  <= dst_addr;
                     mem_wdata <= s1;
                  end
                  OP_ADD, OP_MUL, OP_CMP, OP_SHF, OP_ROT: begin
                     if (dsttype) begin
                        illegal <= 1'b1;
                        state   <= HALT;
                        halted  <= 1'b1;
                        mem_req <= 1'b0;
                     end else begin
                        state   <= WRITE;
                        mem_req <= 1'b0;
                        alu_q   <= alu_res[WIDTH-1:0];
                        psr     <= flags(alu_res);
                     end
                  end
                  OP_HLT: begin
                     state   <= HALT;
                     halted  <= 1'b1;
                     mem_req <= 1'b0;
                  end
                  default: begin
                     illegal <= 1'b1;
                     state   <= HALT;
                     halted  <= 1'b1;
                     mem_req <= 1'b0;
                  end
               endcase
            end

            MEMRD: begin
               if (ack) begin
                  regs[dst_idx] <= mem_rdata;
                  psr           <= flags({1'b0, mem_rdata});
                  state         <= FETCH;
                  mem_addr      <= pc;
               end
            end

            MEMWR: begin
               if (ack) begin
                  psr      <= flags({1'b0, mem_wdata});
                  state    <= FETCH;
                  mem_we   <= 1'b0;
                  mem_addr <= pc;
               end
            end

            WRITE: begin
               regs[dst_idx] <= alu_q;
               state         <= FETCH;
               mem_req       <= 1'b1;
               mem_we        <= 1'b0;
               mem_addr      <= pc;
            end

            default: begin
               state   <= HALT;
               halted  <= 1'b1;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_risc_core_mc.sv
// Directed bench for risc_core_mc: table of single ALU ops plus hand-written
// program sequences for branches, wait states, illegal opcodes and mid-access reset.
module tb_risc_core_mc;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [11:0] pc;
   logic [4:0]  psr;
   logic        halted;
   logic        illegal;

   risc_core_mc dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .pc        (pc),
      .psr       (psr),
      .halted    (halted),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // Program/data image (bench-owned) and store log (responder-owned).
   logic [31:0] mem  [4096];
   logic [31:0] wmem [4096];
   int          ack_delay = 0;
   logic        late_ack  = 1'b0;

   int          wait_cnt    = 0;
   int          n_writes    = 0;
   int          we_cycles   = 0;
   int          we_unstable = 0;
   logic [11:0] we_addr0;
   logic [31:0] we_data0;

   int checks = 0;
   int errors = 0;

   // Memory responder: acks after ack_delay wait cycles, driven on the falling edge.
   always @(negedge clk) begin
      if (!reset) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else if (mem_req) begin
         if (mem_we) begin
            we_cycles++;
            if (wait_cnt == 0) begin
               we_addr0 = mem_addr;
               we_data0 = mem_wdata;
            end else if (mem_addr != we_addr0 || mem_wdata != we_data0) begin
               we_unstable++;
            end
         end
         if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            if (mem_we) begin
               wmem[mem_addr] = mem_wdata;
               n_writes++;
            end
            wait_cnt = 0;
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         mem_ack  = late_ack;
         wait_cnt = 0;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [3:0] op, input logic st, input logic dt,
                                       input logic [11:0] src, input logic [11:0] dst);
      return {op, st, dt, 2'b00, src, dst};
   endfunction

   function automatic logic [31:0] bra(input logic [3:0] cc, input logic [11:0] dst);
      return {4'd1, cc, 12'h000, dst};
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_halt(input string name, input int budget);
      bit done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         if (halted) done = 1'b1;
         else @(negedge clk);
      end
      check({name, "_halt_timeout"}, done, 1'b1);
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [11:0] imm;
      logic [31:0] d;
      logic [31:0] res;
      logic [4:0]  psr;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   int n0, c0, u0;
   bit found;

   initial begin
      // op, immediate s1, preloaded d, expected reg, expected psr {N,Z,P,E,C}
      vecs[0]  = '{4'd4, 12'h001, 32'hFFFF_FFFF, 32'h0000_0000, 5'b00111};
      vecs[1]  = '{4'd4, 12'h005, 32'h0000_0007, 32'h0000_000C, 5'b00010};
      vecs[2]  = '{4'd5, 12'h003, 32'h8000_0000, 32'h8000_0000, 5'b10011};
      vecs[3]  = '{4'd6, 12'h0F0, 32'h1234_5678, 32'hFFFF_FF0F, 5'b10000};
      vecs[4]  = '{4'd7, 12'hFFC, 32'h0000_000F, 32'h0000_00F0, 5'b00010};
      vecs[5]  = '{4'd7, 12'h004, 32'h0000_00F0, 32'h0000_000F, 5'b00000};
      vecs[6]  = '{4'd7, 12'h020, 32'hFFFF_FFFF, 32'h0000_0000, 5'b01010};
      vecs[7]  = '{4'd7, 12'hFE0, 32'h0000_0001, 32'h0000_0000, 5'b01010};
      vecs[8]  = '{4'd8, 12'h001, 32'h0000_0001, 32'h8000_0000, 5'b10110};
      vecs[9]  = '{4'd8, 12'hFFC, 32'hF000_0000, 32'h0000_000F, 5'b00000};
      vecs[10] = '{4'd8, 12'h021, 32'h0000_0003, 32'h8000_0001, 5'b10000};
      vecs[11] = '{4'd8, 12'h800, 32'h1234_5678, 32'h1234_5678, 5'b00110};
      vecs[12] = '{4'd7, 12'h01F, 32'h8000_0000, 32'h0000_0001, 5'b00100};
      vecs[13] = '{4'd5, 12'h000, 32'h0000_0005, 32'h0000_0000, 5'b01010};
      vecs[14] = '{4'd8, 12'h000, 32'h0000_000A, 32'h0000_000A, 5'b00010};
      vecs[15] = '{4'd4, 12'hFFF, 32'h0000_0000, 32'h0000_0FFF, 5'b00000};

      // Reset state and idling in HALT without start.
      clear_mem();
      do_reset();
      check("rst_pc", pc, 12'h000);
      check("rst_psr", psr, 5'b00000);
      check("rst_halted", halted, 1'b1);
      check("rst_illegal", illegal, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      repeat (5) @(negedge clk);
      check("idle_halted", halted, 1'b1);
      check("idle_mem_req", mem_req, 1'b0);
      check("idle_pc", pc, 12'h000);

      // Single ALU operation per vector: LD r1<-[0x100]; op imm,r1; HLT.
      for (int i = 0; i < NV; i++) begin
         clear_mem();
         mem[0]      = enc(4'd2, 1'b0, 1'b0, 12'h100, 12'd1);
         mem[1]      = enc(vecs[i].op, 1'b1, 1'b0, vecs[i].imm, 12'd1);
         mem[2]      = enc(4'd9, 1'b0, 1'b0, 12'h0, 12'h0);
         mem[12'h100] = vecs[i].d;
         do_reset();
         pulse_start();
         wait_halt($sformatf("vec%0d", i), 100);
         check($sformatf("vec%0d_res", i), dut.regs[1], vecs[i].res);
         check($sformatf("vec%0d_psr", i), psr, vecs[i].psr);
      end

      // LD imm / ADD reg / HLT with zero-wait memory.
      clear_mem();
      mem[0] = enc(4'd2, 1'b1, 1'b0, 12'd5, 12'd1);
      mem[1] = enc(4'd2, 1'b1, 1'b0, 12'd7, 12'd2);
      mem[2] = enc(4'd4, 1'b0, 1'b0, 12'd1, 12'd2);
      mem[3] = enc(4'd9, 1'b0, 1'b0, 12'h0, 12'h0);
      do_reset();
      pulse_start();
      wait_halt("add_prog", 100);
      check("add_prog_r1", dut.regs[1], 32'd5);
      check("add_prog_r2", dut.regs[2], 32'd12);
      check("add_prog_psr", psr, 5'b00010);
      check("add_prog_halted", halted, 1'b1);
      check("add_prog_pc", pc, 12'd4);

      // Carry out of ADD, then taken / not-taken / never branches.
      clear_mem();
      mem[0]     = enc(4'd6, 1'b1, 1'b0, 12'h000, 12'd3);
      mem[1]     = enc(4'd4, 1'b1, 1'b0, 12'h001, 12'd3);
      mem[2]     = bra(4'd1, 12'h020);
      mem[3]     = enc(4'd9, 1'b0, 1'b0, 12'h0, 12'h0);
      mem[12'h20] = bra(4'd4, 12'h040);
      mem[12'h21] = bra(4'd6, 12'h040);
      mem[12'h22] = bra(4'd2, 12'h030);
      mem[12'h30] = enc(4'd9, 1'b0, 1'b0, 12'h0, 12'h0);
      mem[12'h40] = enc(4'd9, 1'b0, 1'b0, 12'h0, 12'h0);
      do_reset();
      pulse_start();
      wait_halt("branch", 200);
      check("branch_r3", dut.regs[3], 32'h0);
      check("branch_psr", psr, 5'b00111);
      check("branch_pc", pc, 12'h031);

      // Stores with three wait states on every access.
      clear_mem();
      mem[0] = enc(4'd2, 1'b1, 1'b0, 12'hABC, 12'd4);
      mem[1] = enc(4'd3, 1'b0, 1'b0, 12'd4, 12'h050);
      mem[2] = enc(4'd3, 1'b1, 1'b0, 12'h123, 12'h051);
      mem[3] = enc(4'd9, 1'b0, 1'b0, 12'h0, 12'h0);
      ack_delay = 3;
      do_reset();
      n0 = n_writes;
      c0 = we_cycles;
      u0 = we_unstable;
      pulse_start();
      wait_halt("store", 300);
      check("store_writes", n_writes - n0, 2);
      check("store_we_cycles", we_cycles - c0, 8);
      check("store_unstable", we_unstable - u0, 0);
      check("store_wmem50", wmem[12'h050], 32'h0000_0ABC);
      check("store_wmem51", wmem[12'h051], 32'h0000_0123);
      check("store_pc", pc, 12'd4);
      check("store_psr", psr, 5'b00000);
      ack_delay = 0;

      // Illegal opcode, restart, then ALU op with dsttype=1.
      clear_mem();
      mem[0] = enc(4'd2, 1'b1, 1'b0, 12'd7, 12'd5);
      mem[1] = 32'hA000_0000;
      mem[2] = enc(4'd2, 1'b1, 1'b0, 12'h033, 12'd6);
      mem[3] = enc(4'd9, 1'b0, 1'b0, 12'h0, 12'h0);
      mem[4] = enc(4'd4, 1'b1, 1'b1, 12'h001, 12'd5);
      mem[5] = enc(4'd9, 1'b0, 1'b0, 12'h0, 12'h0);
      do_reset();
      pulse_start();
      wait_halt("illegal_a", 100);
      check("illegal_a_flag", illegal, 1'b1);
      check("illegal_a_pc", pc, 12'd2);
      check("illegal_a_r5", dut.regs[5], 32'd7);
      check("illegal_a_r6", dut.regs[6], 32'd0);
      check("illegal_a_psr", psr, 5'b00100);
      pulse_start();
      check("illegal_clear", illegal, 1'b0);
      check("illegal_resume_running", halted, 1'b0);
      wait_halt("illegal_b", 100);
      check("illegal_b_r6", dut.regs[6], 32'h33);
      check("illegal_b_pc", pc, 12'd4);
      check("illegal_b_flag", illegal, 1'b0);
      pulse_start();
      wait_halt("illegal_c", 100);
      check("illegal_c_flag", illegal, 1'b1);
      check("illegal_c_pc", pc, 12'd5);
      check("illegal_c_r5", dut.regs[5], 32'd7);
      check("illegal_c_psr", psr, 5'b00000);

      // Reset while a load is waiting for its ack; a late ack must do nothing.
      clear_mem();
      mem[0]       = enc(4'd2, 1'b1, 1'b0, 12'h011, 12'd7);
      mem[1]       = enc(4'd2, 1'b0, 1'b0, 12'h100, 12'd8);
      mem[2]       = enc(4'd9, 1'b0, 1'b0, 12'h0, 12'h0);
      mem[12'h100] = 32'hDEAD_BEEF;
      ack_delay = 30;
      do_reset();
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         if (mem_req && !mem_we && mem_addr == 12'h100) found = 1'b1;
         else @(negedge clk);
      end
      check("rstmid_reached_memrd", found, 1'b1);
      reset = 1'b0;
      #1;
      check("rstmid_mem_req", mem_req, 1'b0);
      check("rstmid_pc", pc, 12'd0);
      check("rstmid_halted", halted, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      late_ack = 1'b1;
      repeat (3) @(negedge clk);
      late_ack = 1'b0;
      ack_delay = 0;
      @(negedge clk);
      check("rstmid_r8", dut.regs[8], 32'd0);
      check("rstmid_r7", dut.regs[7], 32'd0);
      check("rstmid_psr", psr, 5'b00000);
      check("rstmid_still_halted", halted, 1'b1);
      check("rstmid_pc_after", pc, 12'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
